execute_issue_stage: RTL and testbench

EXECUTE_ISSUE_STAGE -- requirements
Module: execute_issue_stage

---
 rtl/alu_pkg.sv | 24 ++
 rtl/execute_issue_stage_forward_unit.sv | 44 ++++
 rtl/execute_issue_stage.sv | 162 ++++++++++++++++
 tb/tb_execute_issue_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode and forwarding-select definitions for the execute slice.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND      = 4'd0,
        ALU_OR       = 4'd1,
        ALU_NOR      = 4'd2,
        ALU_ADD      = 4'd3,
        ALU_SUB      = 4'd4,
        ALU_INC      = 4'd5,
        ALU_MULTPLUS = 4'd6,
        ALU_MOV      = 4'd7
    } alu_op_e;

    // Opcode driven while the execute stage holds a bubble.
    localparam logic [3:0] ALU_BUBBLE = 4'b0000;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

endpackage

// File: rtl/execute_issue_stage_forward_unit.sv
// Operand forwarding for one source register: MEM result beats WB result,
// which beats the registered register-file value. r0 is never forwarded.
module forward_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  src_reg,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [DATA_W-1:0] rf_value,
    output logic [DATA_W-1:0] value
);

    fwd_sel_e sel;

    // Pick the youngest producer of src_reg.
    always_comb begin
        sel = FWD_RF;
        if (src_reg != '0) begin
            if (mem_reg_write && (mem_dest == src_reg)) begin
                sel = FWD_MEM;
            end else if (wb_reg_write && (wb_dest == src_reg)) begin
                sel = FWD_WB;
            end
        end
    end

    // Operand mux driven by the selection above.
    always_comb begin
        value = rf_value;
        case (sel)
            FWD_MEM: value = mem_result;
            FWD_WB:  value = wb_result;
            default: value = rf_value;
        endcase
    end

endmodule

// File: rtl/execute_issue_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection,
// bubble insertion and operand forwarding.
// Build option: define EXEC_FORWARDING_EN to enable the MEM/WB forwarding
// paths; without it operands come straight from the pipeline register and
// any pending write to a source register stalls decode.
module execute_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_aluop,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_alu_src,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [3:0]        ex_aluop,
    output logic [REG_W-1:0]  ex_dest,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [15:0]       stall_count
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              alu_src;
        logic [3:0]        aluop;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } ex_reg_t;

    ex_reg_t           ex_q, ex_d;
    logic [15:0]       stall_count_q, stall_count_d;
    logic              hazard;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    function automatic logic id_reads(input logic [REG_W-1:0] r);
        return id_valid && (r != '0) && ((r == id_rs) || (r == id_rt));
    endfunction

    // Hazard detection against instructions still ahead in the pipe.
    always_comb begin
        hazard = ex_q.valid && ex_q.mem_read && id_reads(ex_q.dest);
`ifndef EXEC_FORWARDING_EN
        hazard = hazard
              || (ex_q.reg_write && id_reads(ex_q.dest))
              || (mem_reg_write  && id_reads(mem_dest))
              || (wb_reg_write   && id_reads(wb_dest));
`endif
    end

    // Reset masks stall so a stalled instruction is simply dropped.
    assign stall = hazard && !flush && !reset;

    // Next pipeline contents: bubble on flush/stall, else capture decode.
    always_comb begin
        ex_d       = '0;
        ex_d.aluop = ALU_BUBBLE;
        if (!flush && !stall) begin
            ex_d.valid     = id_valid;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.alu_src   = id_alu_src;
            ex_d.aluop     = id_aluop;
            ex_d.dest      = id_dest;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.rd1       = id_read_data1;
            ex_d.rd2       = id_read_data2;
            ex_d.imm       = id_imm;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

`ifdef EXEC_FORWARDING_EN
    forward_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .src_reg       (ex_q.rs),
        .mem_reg_write (mem_reg_write),
        .mem_dest      (mem_dest),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .wb_result     (wb_result),
        .rf_value      (ex_q.rd1),
        .value         (fwd_rs)
    );

    forward_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .src_reg       (ex_q.rt),
        .mem_reg_write (mem_reg_write),
        .mem_dest      (mem_dest),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .wb_result     (wb_result),
        .rf_value      (ex_q.rd2),
        .value         (fwd_rt)
    );
`else
    assign fwd_rs = ex_q.rd1;
    assign fwd_rt = ex_q.rd2;

    // Results and source indices only feed the forwarding muxes.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_result, wb_result, ex_q.rs, ex_q.rt};
`endif

    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_aluop      = ex_q.aluop;
    assign ex_dest       = ex_q.dest;
    assign ex_a          = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign ex_b          = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_execute_issue_stage.sv
// Self-checking bench for execute_issue_stage against a behavioural model.
// Follows EXEC_FORWARDING_EN the same way the design does.
module tb_execute_issue_stage;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_reg_write, id_mem_read, id_alu_src;
    logic [3:0]    id_aluop;
    logic [RW-1:0] id_rs, id_rt, id_dest;
    logic [DW-1:0] id_read_data1, id_read_data2, id_imm;
    logic          flush, mem_reg_write, wb_reg_write;
    logic [RW-1:0] mem_dest, wb_dest;
    logic [DW-1:0] mem_result, wb_result;
    logic          stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [3:0]    ex_aluop;
    logic [RW-1:0] ex_dest;
    logic [DW-1:0] ex_a, ex_b, ex_store_data;
    logic [15:0]   stall_count;

    always #5 clk = ~clk;

    execute_issue_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_alu_src(id_alu_src),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
        .flush(flush), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_dest(mem_dest), .wb_dest(wb_dest), .mem_result(mem_result), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_aluop(ex_aluop), .ex_dest(ex_dest), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .stall_count(stall_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently sitting in execute.
    logic          m_valid = 0, m_rw = 0, m_mr = 0, m_alu_src = 0;
    logic [3:0]    m_op = 0;
    logic [RW-1:0] m_dest = 0, m_rs = 0, m_rt = 0;
    logic [DW-1:0] m_rd1 = 0, m_rd2 = 0, m_imm = 0;
    int unsigned   m_cnt = 0;
    logic          e_stall;
    logic [DW-1:0] e_a, e_b, e_sd;

    function automatic bit reads(input logic [RW-1:0] r);
        return id_valid && (r != 0) && ((r == id_rs) || (r == id_rt));
    endfunction

`ifdef EXEC_FORWARDING_EN
    function automatic logic [DW-1:0] fwd_val(input logic [RW-1:0] r, input logic [DW-1:0] rf);
        if (r != 0 && mem_reg_write && mem_dest == r) return mem_result;
        if (r != 0 && wb_reg_write && wb_dest == r) return wb_result;
        return rf;
    endfunction
`endif

    task automatic model_eval();
        bit hz;
        hz = m_valid && m_mr && reads(m_dest);
`ifdef EXEC_FORWARDING_EN
        e_a  = fwd_val(m_rs, m_rd1);
        e_sd = fwd_val(m_rt, m_rd2);
`else
        hz = hz || (m_rw && reads(m_dest)) || (mem_reg_write && reads(mem_dest))
                || (wb_reg_write && reads(wb_dest));
        e_a  = m_rd1;
        e_sd = m_rd2;
`endif
        e_stall = hz && !flush && !reset;
        e_b = m_alu_src ? m_imm : e_sd;
    endtask

    task automatic model_edge();
        model_eval();
        if (!reset && e_stall && m_cnt < 65535) m_cnt++;
        if (reset) m_cnt = 0;
        if (reset || flush || e_stall) begin
            {m_valid, m_rw, m_mr, m_alu_src, m_op, m_dest, m_rs, m_rt} = '0;
            {m_rd1, m_rd2, m_imm} = '0;
        end else begin
            m_valid = id_valid; m_rw = id_reg_write; m_mr = id_mem_read;
            m_alu_src = id_alu_src; m_op = id_aluop; m_dest = id_dest;
            m_rs = id_rs; m_rt = id_rt; m_rd1 = id_read_data1;
            m_rd2 = id_read_data2; m_imm = id_imm;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; flush = 0;
        {id_valid, id_reg_write, id_mem_read, id_alu_src} = '0;
        id_aluop = 0; id_rs = 0; id_rt = 0; id_dest = 0;
        id_read_data1 = 0; id_read_data2 = 0; id_imm = 0;
        mem_reg_write = 0; wb_reg_write = 0; mem_dest = 0; wb_dest = 0;
        mem_result = 0; wb_result = 0;
    endtask

    task automatic idle();
        clear_inputs();
        advance();
    endtask

    task automatic load_r5();
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_dest = 5;
        id_rs = 1; id_rt = 2; id_aluop = ALU_ADD;
        advance();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; id_valid = 1; id_rs = 5; id_rt = 5; id_aluop = ALU_MOV;
        id_mem_read = 1; id_reg_write = 1; id_dest = 5;
        id_read_data1 = $urandom; id_read_data2 = $urandom;
        advance();
        settle();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_during got %b want 0", stall); end
        advance();
        reset = 0;
        settle();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
        checks++;
        if (ex_aluop !== 4'd0) begin errors++; $display("FAIL reset_ex_aluop got %0d want 0", ex_aluop); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_after got %b want 0", stall); end
        checks++;
        if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
        checks++;
        if (ex_a !== 32'd0) begin errors++; $display("FAIL reset_ex_a got %h want 0", ex_a); end
        advance();
    endtask

    task automatic test_forward_priority();
        logic [DW-1:0] want;
        idle();
        id_valid = 1; id_aluop = ALU_ADD; id_rs = 2; id_rt = 3; id_dest = 4;
        id_reg_write = 1; id_read_data1 = 32'hAA; id_read_data2 = 32'hBB;
        advance();
        clear_inputs();
        mem_reg_write = 1; mem_dest = 2; mem_result = 32'h11;
        wb_reg_write = 1; wb_dest = 2; wb_result = 32'h22;
        settle();
`ifdef EXEC_FORWARDING_EN
        want = 32'h11;
`else
        want = 32'hAA;
`endif
        checks++;
        if (ex_a !== want) begin errors++; $display("FAIL fwd_mem_priority got %h want %h", ex_a, want); end
        checks++;
        if (ex_store_data !== e_sd) begin errors++; $display("FAIL fwd_rt_path got %h want %h", ex_store_data, e_sd); end
        checks++;
        if (ex_aluop !== ALU_ADD || ex_valid !== 1'b1) begin
            errors++; $display("FAIL fwd_issue got op=%0d v=%b want op=3 v=1", ex_aluop, ex_valid);
        end
        advance();
    endtask

    task automatic test_load_use();
        int unsigned cnt0;
        idle();
        cnt0 = m_cnt;
        load_r5();
        id_valid = 1; id_mem_read = 0; id_reg_write = 1; id_dest = 6;
        id_rs = 5; id_rt = 0; id_aluop = ALU_SUB;
        settle();
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b want 1", stall); end
        advance();
        settle();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_one_cycle got %b want 0", stall); end
        checks++;
        if (ex_valid !== 1'b0 || ex_aluop !== 4'd0) begin
            errors++; $display("FAIL loaduse_bubble got v=%b op=%0d want v=0 op=0", ex_valid, ex_aluop);
        end
        checks++;
        if (stall_count !== 16'(cnt0 + 1)) begin
            errors++; $display("FAIL loaduse_count got %0d want %0d", stall_count, cnt0 + 1);
        end
        advance();
        id_valid = 0;
        settle();
        checks++;
        if (ex_valid !== 1'b1 || ex_aluop !== ALU_SUB || ex_dest !== 5'd6) begin
            errors++; $display("FAIL loaduse_issue got v=%b op=%0d d=%0d want v=1 op=4 d=6", ex_valid, ex_aluop, ex_dest);
        end
        advance();
    endtask

    task automatic test_flush_hazard();
        int unsigned cnt0;
        idle();
        load_r5();
        cnt0 = m_cnt;
        id_valid = 1; id_mem_read = 0; id_rs = 5; id_aluop = ALU_OR; flush = 1;
        settle();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        advance();
        clear_inputs();
        settle();
        checks++;
        if (ex_valid !== 1'b0 || ex_aluop !== 4'd0) begin
            errors++; $display("FAIL flush_bubble got v=%b op=%0d want v=0 op=0", ex_valid, ex_aluop);
        end
        checks++;
        if (stall_count !== 16'(cnt0)) begin
            errors++; $display("FAIL flush_count got %0d want %0d", stall_count, cnt0);
        end
        advance();
    endtask

    task automatic test_zero_reg();
        idle();
        mem_reg_write = 1; mem_dest = 0; mem_result = 32'hDEADBEEF;
        id_valid = 1; id_rs = 0; id_rt = 7; id_read_data1 = 0; id_read_data2 = 32'h1234;
        id_alu_src = 1; id_imm = 32'hFFFFFFFC; id_aluop = ALU_ADD; id_dest = 8; id_reg_write = 1;
        advance();
        id_valid = 0;
        settle();
        checks++;
        if (ex_a !== 32'd0) begin errors++; $display("FAIL zero_reg_ex_a got %h want 0", ex_a); end
        checks++;
        if (ex_b !== 32'hFFFFFFFC) begin errors++; $display("FAIL zero_reg_ex_b got %h want fffffffc", ex_b); end
        checks++;
        if (ex_store_data !== 32'h1234) begin errors++; $display("FAIL zero_reg_sd got %h want 1234", ex_store_data); end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_aluop = 4'($urandom_range(0, 7));
            id_rs = RW'($urandom_range(0, 7)); id_rt = RW'($urandom_range(0, 7));
            id_dest = RW'($urandom_range(0, 7));
            id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
            id_alu_src = 1'($urandom);
            id_read_data1 = $urandom; id_read_data2 = $urandom; id_imm = $urandom;
            mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
            mem_dest = RW'($urandom_range(0, 7)); wb_dest = RW'($urandom_range(0, 7));
            mem_result = $urandom; wb_result = $urandom;
            settle();
            checks++;
            if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", i, stall, e_stall); end
            checks++;
            if (ex_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, ex_valid, m_valid); end
            checks++;
            if (ex_reg_write !== m_rw) begin errors++; $display("FAIL rnd_reg_write cyc %0d got %b want %b", i, ex_reg_write, m_rw); end
            checks++;
            if (ex_mem_read !== m_mr) begin errors++; $display("FAIL rnd_mem_read cyc %0d got %b want %b", i, ex_mem_read, m_mr); end
            checks++;
            if (ex_aluop !== m_op) begin errors++; $display("FAIL rnd_aluop cyc %0d got %0d want %0d", i, ex_aluop, m_op); end
            checks++;
            if (ex_dest !== m_dest) begin errors++; $display("FAIL rnd_dest cyc %0d got %0d want %0d", i, ex_dest, m_dest); end
            checks++;
            if (ex_a !== e_a) begin errors++; $display("FAIL rnd_ex_a cyc %0d got %h want %h", i, ex_a, e_a); end
            checks++;
            if (ex_b !== e_b) begin errors++; $display("FAIL rnd_ex_b cyc %0d got %h want %h", i, ex_b, e_b); end
            checks++;
            if (ex_store_data !== e_sd) begin errors++; $display("FAIL rnd_store cyc %0d got %h want %h", i, ex_store_data, e_sd); end
            checks++;
            if (stall_count !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, stall_count, m_cnt); end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int bad = 0;
        idle();
`ifdef EXEC_FORWARDING_EN
        // Back-to-back dependent loads: at most one stall every two cycles.
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_dest = 5; id_rs = 5; id_aluop = ALU_ADD;
        for (int i = 0; i < 200; i++) begin
            settle();
            if (stall !== e_stall) bad++;
            advance();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL chain_stall got %0d bad cycles want 0", bad); end
        checks++;
        if (stall_count !== 16'(m_cnt)) begin errors++; $display("FAIL chain_count got %0d want %0d", stall_count, m_cnt); end
`else
        // A pending WB write to a source register stalls every cycle.
        id_valid = 1; id_rs = 3; id_aluop = ALU_ADD; wb_reg_write = 1; wb_dest = 3;
        settle();
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL wb_dep_stall got %b want 1", stall); end
        for (int i = 0; i < 65540; i++) begin
            settle();
            if (stall !== 1'b1) bad++;
            advance();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wb_dep_held got %0d bad cycles want 0", bad); end
        settle();
        checks++;
        if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h want ffff", stall_count); end
        checks++;
        if (stall_count !== 16'(m_cnt)) begin errors++; $display("FAIL sat_model got %0d want %0d", stall_count, m_cnt); end
`endif
        clear_inputs();
        advance();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forward_priority();
        test_load_use();
        test_flush_hazard();
        test_zero_reg();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
